// File: rtl/axi_cmd_pkg.sv
// Shared types and constants for the AXI command sequencer.
// State encoding and AXI response codes.
package axi_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_cmd_fifo.sv
// Synchronous command FIFO with full/empty flags and occupancy.
// Head entry is presented combinationally on pop_data.
module axi_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage array; no reset needed, validity tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Occupancy; simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axi_cmd_sequencer.sv
// Queued command front-end for the simple m_wr_*/m_rd_* master port.
// One request in flight; responses returned in command order.
module axi_cmd_sequencer
  import axi_cmd_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_data,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic [1:0]              rsp_resp,
  output logic                    m_wr_req,
  output logic [ADDR_WIDTH-1:0]   m_wr_addr,
  output logic [DATA_WIDTH-1:0]   m_wr_data,
  output logic [DATA_WIDTH/8-1:0] m_wr_strb,
  input  logic                    m_wr_done,
  input  logic [1:0]              m_wr_resp,
  output logic                    m_rd_req,
  output logic [ADDR_WIDTH-1:0]   m_rd_addr,
  input  logic [DATA_WIDTH-1:0]   m_rd_data,
  input  logic                    m_rd_done,
  input  logic [1:0]              m_rd_resp,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  cmd_count
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int FW = 1 + ADDR_WIDTH + DATA_WIDTH + SW;

  state_t state;
  state_t state_next;

  logic                  full;
  logic                  empty;
  logic                  pop;
  logic                  capture;
  logic [FW-1:0]         head;
  logic                  head_write;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;
  logic [SW-1:0]         head_strb;

  logic                  cur_write;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0] cur_data;
  logic [SW-1:0]         cur_strb;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic [1:0]            rsp_resp_q;

  // Held low during reset so every output reads 0 there.
  assign cmd_ready = !full && !areset;

  axi_cmd_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (aclk),
    .rst       (areset),
    .push      (cmd_valid && cmd_ready),
    .push_data ({cmd_write, cmd_addr, cmd_data, cmd_strb}),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (cmd_count)
  );

  assign {head_write, head_addr, head_data, head_strb} = head;

  assign m_wr_addr = cur_addr;
  assign m_rd_addr = cur_addr;
  assign m_wr_data = cur_data;
  assign m_wr_strb = cur_strb;
  assign rsp_write = cur_write;
  assign rsp_data  = rsp_data_q;
  assign rsp_resp  = rsp_resp_q;
  assign busy      = (state != IDLE) || !empty;

  // State register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and per-state strobes; only the issued channel's done counts.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    capture    = 1'b0;
    m_wr_req   = 1'b0;
    m_rd_req   = 1'b0;
    rsp_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        m_wr_req   = cur_write;
        m_rd_req   = !cur_write;
        state_next = WAIT;
      end
      WAIT: begin
        if (cur_write ? m_wr_done : m_rd_done) begin
          capture    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Current command; holds request fields stable until the next pop.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cur_write <= 1'b0;
      cur_addr  <= '0;
      cur_data  <= '0;
      cur_strb  <= '0;
    end else if (pop) begin
      cur_write <= head_write;
      cur_addr  <= head_addr;
      cur_data  <= head_data;
      cur_strb  <= head_strb;
    end
  end

  // Response capture; resp code passed through untouched.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rsp_data_q <= '0;
      rsp_resp_q <= RESP_OKAY;
    end else if (capture) begin
      rsp_resp_q <= cur_write ? m_wr_resp : m_rd_resp;
      rsp_data_q <= cur_write ? '0 : m_rd_data;
    end
  end

endmodule

// File: tb/tb_axi_cmd_sequencer.sv
// Directed bench for axi_cmd_sequencer.
// Hand-computed expectations checked with immediate assertions.
module tb_axi_cmd_sequencer;
  import axi_cmd_pkg::*;

  logic        aclk = 1'b0;
  logic        areset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_data;
  logic [3:0]  cmd_strb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_write;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_resp;
  logic        m_wr_req;
  logic [31:0] m_wr_addr;
  logic [31:0] m_wr_data;
  logic [3:0]  m_wr_strb;
  logic        m_wr_done;
  logic [1:0]  m_wr_resp;
  logic        m_rd_req;
  logic [31:0] m_rd_addr;
  logic [31:0] m_rd_data;
  logic        m_rd_done;
  logic [1:0]  m_rd_resp;
  logic        busy;
  logic [2:0]  cmd_count;

  int checks = 0;
  int errors = 0;
  int wr_pulses = 0;
  int rd_pulses = 0;
  int w0;
  int r0;

  axi_cmd_sequencer #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .DEPTH      (4)
  ) dut (
    .aclk      (aclk),
    .areset    (areset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .cmd_strb  (cmd_strb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_write (rsp_write),
    .rsp_data  (rsp_data),
    .rsp_resp  (rsp_resp),
    .m_wr_req  (m_wr_req),
    .m_wr_addr (m_wr_addr),
    .m_wr_data (m_wr_data),
    .m_wr_strb (m_wr_strb),
    .m_wr_done (m_wr_done),
    .m_wr_resp (m_wr_resp),
    .m_rd_req  (m_rd_req),
    .m_rd_addr (m_rd_addr),
    .m_rd_data (m_rd_data),
    .m_rd_done (m_rd_done),
    .m_rd_resp (m_rd_resp),
    .busy      (busy),
    .cmd_count (cmd_count)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    if (m_wr_req) wr_pulses <= wr_pulses + 1;
    if (m_rd_req) rd_pulses <= rd_pulses + 1;
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_strb  = s;
    chk("push_ready", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic issue(input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (w ? m_wr_req : m_rd_req) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    chk("issue_seen", seen, 1);
    chk("issue_addr", w ? m_wr_addr : m_rd_addr, a);
    chk("issue_other_req", w ? m_rd_req : m_wr_req, 0);
    if (w) begin
      chk("issue_wdata", m_wr_data, d);
      chk("issue_wstrb", m_wr_strb, s);
    end
    step();
  endtask

  task automatic complete(input logic w, input logic [1:0] r,
                          input logic [31:0] d);
    if (w) begin
      m_wr_done = 1'b1;
      m_wr_resp = r;
    end else begin
      m_rd_done = 1'b1;
      m_rd_resp = r;
      m_rd_data = d;
    end
    step();
    m_wr_done = 1'b0;
    m_rd_done = 1'b0;
  endtask

  task automatic take_rsp(input logic w, input logic [31:0] d,
                          input logic [1:0] r);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_write", rsp_write, w);
    chk("rsp_data", rsp_data, d);
    chk("rsp_resp", rsp_resp, r);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rsp_drop", rsp_valid, 0);
  endtask

  initial begin
    areset    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_data  = '0;
    cmd_strb  = '0;
    rsp_ready = 1'b0;
    m_wr_done = 1'b0;
    m_wr_resp = '0;
    m_rd_done = 1'b0;
    m_rd_resp = '0;
    m_rd_data = '0;

    // Reset state
    repeat (2) step();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_count", cmd_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_wr_req", m_wr_req, 0);
    chk("rst_rsp_data", rsp_data, 0);
    areset = 1'b0;
    #1;
    chk("post_rst_ready", cmd_ready, 1);

    // Single write: req two cycles after accept, done two after req
    push(1'b1, 32'h4, 32'hDEADBEEF, 4'hF);
    chk("w1_count", cmd_count, 1);
    chk("w1_busy", busy, 1);
    chk("w1_no_req_yet", m_wr_req, 0);
    step();
    chk("w1_req_latency", m_wr_req, 1);
    issue(1'b1, 32'h4, 32'hDEADBEEF, 4'hF);
    chk("w1_req_one_cycle", m_wr_req, 0);
    step();
    chk("w1_wait_no_rsp", rsp_valid, 0);
    complete(1'b1, RESP_OKAY, 32'h0);
    chk("w1_one_pulse", wr_pulses, 1);
    take_rsp(1'b1, 32'h0, RESP_OKAY);
    chk("w1_idle", busy, 0);

    // Read, with a stray write done ignored while waiting
    w0 = wr_pulses;
    push(1'b0, 32'h4, 32'h0, 4'h0);
    issue(1'b0, 32'h4, 32'h0, 4'h0);
    m_wr_done = 1'b1;
    m_wr_resp = RESP_DECERR;
    step();
    m_wr_done = 1'b0;
    chk("rd_other_done_ignored", rsp_valid, 0);
    complete(1'b0, RESP_OKAY, 32'hDEADBEEF);
    take_rsp(1'b0, 32'hDEADBEEF, RESP_OKAY);
    chk("rd_no_wr_req", wr_pulses, w0);

    // Full FIFO: first popped, next four fill, sixth stalls
    r0 = rd_pulses;
    for (int i = 0; i < 5; i++)
      push(1'b0, 32'(32'h100 + i * 4), 32'h0, 4'h0);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h114;
    chk("full_ready", cmd_ready, 0);
    chk("full_count", cmd_count, 4);
    repeat (3) step();
    chk("full_count_hold", cmd_count, 4);
    chk("full_ready_hold", cmd_ready, 0);
    chk("full_one_issue", rd_pulses - r0, 1);
    complete(1'b0, RESP_OKAY, 32'hA000_0100);
    take_rsp(1'b0, 32'hA000_0100, RESP_OKAY);
    chk("full_idle_ready", cmd_ready, 0);
    step();
    chk("full_slot_ready", cmd_ready, 1);
    chk("full_slot_count", cmd_count, 3);
    chk("full_c1_req", m_rd_req, 1);
    chk("full_c1_addr", m_rd_addr, 32'h104);
    step();
    cmd_valid = 1'b0;
    chk("full_refill", cmd_count, 4);
    complete(1'b0, RESP_OKAY, 32'hA000_0104);
    take_rsp(1'b0, 32'hA000_0104, RESP_OKAY);
    for (int i = 2; i < 6; i++) begin
      issue(1'b0, 32'(32'h100 + i * 4), 32'h0, 4'h0);
      complete(1'b0, RESP_OKAY, 32'(32'hA000_0100 + i * 4));
      take_rsp(1'b0, 32'(32'hA000_0100 + i * 4), RESP_OKAY);
    end
    chk("full_drained", cmd_count, 0);

    // Backpressure with two commands queued behind a pending response
    push(1'b1, 32'h20, 32'h1111_2222, 4'h3);
    push(1'b0, 32'h24, 32'h0, 4'h0);
    push(1'b0, 32'h28, 32'h0, 4'h0);
    chk("bp_count", cmd_count, 2);
    complete(1'b1, RESP_OKAY, 32'h0);
    w0 = wr_pulses;
    r0 = rd_pulses;
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_count_hold", cmd_count, 2);
      chk("bp_stable", {rsp_write, rsp_resp, rsp_data}, {1'b1, 2'b00, 32'h0});
      step();
    end
    chk("bp_no_wr_req", wr_pulses, w0);
    chk("bp_no_rd_req", rd_pulses, r0);
    take_rsp(1'b1, 32'h0, RESP_OKAY);
    issue(1'b0, 32'h24, 32'h0, 4'h0);
    complete(1'b0, RESP_OKAY, 32'h5555_AAAA);
    take_rsp(1'b0, 32'h5555_AAAA, RESP_OKAY);
    issue(1'b0, 32'h28, 32'h0, 4'h0);
    complete(1'b0, RESP_EXOKAY, 32'h0F0F_0F0F);
    take_rsp(1'b0, 32'h0F0F_0F0F, RESP_EXOKAY);

    // Error passthrough, then a write ignoring a done in its issue cycle
    push(1'b0, 32'h30, 32'h0, 4'h0);
    push(1'b1, 32'h34, 32'hCAFE_F00D, 4'h5);
    issue(1'b0, 32'h30, 32'h0, 4'h0);
    complete(1'b0, RESP_SLVERR, 32'h0BAD_BAD0);
    take_rsp(1'b0, 32'h0BAD_BAD0, RESP_SLVERR);
    step();
    chk("err_next_req", m_wr_req, 1);
    chk("err_next_addr", m_wr_addr, 32'h34);
    chk("err_next_data", m_wr_data, 32'hCAFE_F00D);
    m_wr_done = 1'b1;
    m_wr_resp = RESP_DECERR;
    step();
    m_wr_done = 1'b0;
    chk("issue_done_a", rsp_valid, 0);
    step();
    chk("issue_done_b", rsp_valid, 0);
    complete(1'b1, RESP_OKAY, 32'h0);
    take_rsp(1'b1, 32'h0, RESP_OKAY);

    // Reset while waiting with two commands queued
    push(1'b0, 32'h40, 32'h0, 4'h0);
    push(1'b1, 32'h44, 32'h1, 4'hF);
    push(1'b1, 32'h48, 32'h2, 4'hF);
    chk("rw_count", cmd_count, 2);
    areset = 1'b1;
    #1;
    chk("rw_rsp_valid", rsp_valid, 0);
    chk("rw_wr_req", m_wr_req, 0);
    chk("rw_rd_req", m_rd_req, 0);
    chk("rw_count0", cmd_count, 0);
    chk("rw_busy", busy, 0);
    chk("rw_ready", cmd_ready, 0);
    step();
    areset = 1'b0;
    w0 = wr_pulses;
    r0 = rd_pulses;
    m_rd_done = 1'b1;
    m_rd_resp = RESP_SLVERR;
    step();
    m_rd_done = 1'b0;
    repeat (3) step();
    chk("rw_late_no_rsp", rsp_valid, 0);
    chk("rw_late_idle", busy, 0);
    chk("rw_no_reissue", (wr_pulses - w0) + (rd_pulses - r0), 0);
    push(1'b1, 32'h50, 32'h1234_5678, 4'hF);
    issue(1'b1, 32'h50, 32'h1234_5678, 4'hF);
    complete(1'b1, RESP_OKAY, 32'h0);
    take_rsp(1'b1, 32'h0, RESP_OKAY);
    chk("rw_final_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
